branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
module branch_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [PC_WIDTH-1:0]   predict_next_pc,
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic                  update_taken,
    input  logic                  update_uncond,
    input  logic [PC_WIDTH-1:0]   update_target,
    input  logic                  update_mispredict,
    input  logic                  flush_all,
    output logic [STAT_WIDTH-1:0] mispredict_count
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = PC_WIDTH - IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]    valid_q;
    logic [ENTRIES-1:0]    uncond_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0]   target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0]   lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [IDX_BITS-1:0]   up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic [CTR_BITS-1:0]   ctr_upd;
    logic                  unused_ok;

    assign unused_ok = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_BITS+1:2];
    assign lk_tag = lookup_pc[PC_WIDTH-1:IDX_BITS+2];
    assign up_idx = update_pc[IDX_BITS+1:2];
    assign up_tag = update_pc[PC_WIDTH-1:IDX_BITS+2];

    assign predict_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign predict_taken   = predict_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    assign predict_next_pc = predict_taken ? target_q[lk_idx] : lookup_pc + PC_WIDTH'(4);

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Counter step for a hitting update; unconditional branches pin it high.
    always_comb begin
        ctr_upd = ctr_q[up_idx];
        if (update_uncond) begin
            ctr_upd = CTR_MAX;
        end else if (update_taken) begin
            if (ctr_q[up_idx] != CTR_MAX) ctr_upd = ctr_q[up_idx] + CTR_BITS'(1);
        end else begin
            if (ctr_q[up_idx] != '0) ctr_upd = ctr_q[up_idx] - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q  <= '0;
            uncond_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_upd;
                if (update_uncond) uncond_q[up_idx] <= 1'b1;
                if (update_taken)  target_q[up_idx] <= update_target;
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                uncond_q[up_idx] <= update_uncond;
                ctr_q[up_idx]    <= update_uncond ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    // Statistic survives flush_all; only reset clears it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mispredict_count <= '0;
        end else if (update_valid && update_mispredict && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + STAT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks against a table model
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] lookup_pc;
    logic        predict_hit;
    logic        predict_taken;
    logic [31:0] predict_next_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_uncond;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        flush_all;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    bit          m_valid  [16];
    int unsigned m_tag    [16];
    int unsigned m_target [16];
    int          m_ctr    [16];
    bit          m_uncond [16];
    int          m_count;

    branch_predictor dut (
        .clk               (clk),
        .nreset            (nreset),
        .lookup_pc         (lookup_pc),
        .predict_hit       (predict_hit),
        .predict_taken     (predict_taken),
        .predict_next_pc   (predict_next_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_uncond     (update_uncond),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .flush_all         (flush_all)   ,
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0; m_uncond[i] = 0;
        end
        m_count = 0;
    endtask

    // Applies the architectural rules to the table for the inputs currently driven.
    task automatic model_commit();
        int unsigned idx, tg;
        idx = (update_pc / 4) % 16;
        tg  = update_pc / 64;
        if (update_valid && update_mispredict && m_count < 65535) m_count++;
        if (flush_all) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (update_valid) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (update_uncond) begin
                    m_ctr[idx] = 3; m_uncond[idx] = 1;
                    if (update_taken) m_target[idx] = update_target;
                end else if (update_taken) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_target[idx] = update_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (update_taken) begin
                m_valid[idx] = 1; m_tag[idx] = tg; m_target[idx] = update_target;
                m_uncond[idx] = update_uncond;
                m_ctr[idx] = update_uncond ? 3 : 2;
            end
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
        update_valid = 0;
        flush_all    = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input bit tk, input bit unc,
                         input logic [31:0] tgt, input bit mis);
        update_valid = 1; update_pc = pc; update_taken = tk;
        update_uncond = unc; update_target = tgt; update_mispredict = mis;
    endtask

    task automatic check(input logic [31:0] pc, input string name);
        int unsigned idx;
        bit          e_hit, e_taken;
        logic [31:0] e_next;
        lookup_pc = pc;
        #1;
        idx     = (pc / 4) % 16;
        e_hit   = m_valid[idx] && (m_tag[idx] == pc / 64);
        e_taken = e_hit && (m_uncond[idx] || m_ctr[idx] >= 2);
        e_next  = e_taken ? m_target[idx] : 32'((longint'(pc) + 4) % 64'h1_0000_0000);
        checks++;
        assert (predict_hit === e_hit) else begin
            errors++; $error("FAIL %s hit got %0b want %0b", name, predict_hit, e_hit);
        end
        checks++;
        assert (predict_taken === e_taken) else begin
            errors++; $error("FAIL %s taken got %0b want %0b", name, predict_taken, e_taken);
        end
        checks++;
        assert (predict_next_pc === e_next) else begin
            errors++; $error("FAIL %s next_pc got %h want %h", name, predict_next_pc, e_next);
        end
        checks++;
        assert (mispredict_count === 16'(m_count)) else begin
            errors++; $error("FAIL %s count got %0d want %0d", name, mispredict_count, m_count);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned hi;
        hi = $urandom_range(0, 3);
        if (hi == 3) hi = 32'h03FF_FFFF;
        return (hi << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        nreset = 0; lookup_pc = 0; update_valid = 0; update_pc = 0; update_taken = 0;
        update_uncond = 0; update_target = 0; update_mispredict = 0; flush_all = 0;
        model_reset();
        #12;
        check(32'h40, "reset");
        check(32'hFFFF_FFFC, "reset_wrap");
        nreset = 1;
        @(posedge clk); #1;

        drive(32'h40, 1, 0, 32'h100, 1);
        check(32'h40, "same_cycle_old");
        tick();
        check(32'h40, "alloc");

        drive(32'h40, 0, 0, 32'h0, 0); tick(); check(32'h40, "nt_ctr1");
        drive(32'h40, 0, 0, 32'h0, 0); tick(); check(32'h40, "nt_ctr0");
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 1, 0, 32'h100, 0); tick();
        end
        check(32'h40, "sat_taken");
        drive(32'h40, 0, 0, 32'h0, 0); tick(); check(32'h40, "hysteresis");

        drive(32'h80, 1, 0, 32'h200, 0); tick();
        check(32'h40, "alias_old");
        check(32'h80, "alias_new");
        drive(32'hC0, 0, 0, 32'h300, 0); tick(); check(32'h80, "nt_miss_keeps");

        drive(32'h20, 1, 1, 32'h8, 0); tick(); check(32'h20, "uncond");
        drive(32'h20, 0, 0, 32'h0, 0); tick(); check(32'h20, "uncond_pinned");

        drive(32'h40, 1, 0, 32'h500, 1); flush_all = 1; tick();
        check(32'h40, "flush_drop");
        check(32'h80, "flush_80");
        check(32'h20, "flush_20");

        for (int n = 0; n < 400; n++) begin
            bit unc;
            unc = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0)
                drive(rand_pc(), unc ? 1'b1 : 1'($urandom), unc, $urandom, 1'($urandom));
            flush_all = ($urandom_range(0, 40) == 0);
            check(rand_pc(), "random_pre");
            tick();
        end

        for (int n = 0; n < 65541; n++) begin
            drive(32'h1000, 0, 0, 32'h0, 1);
            tick();
        end
        check(32'h1000, "count_sat");
        drive(32'h1000, 0, 0, 32'h0, 1); tick();
        check(32'h1000, "count_hold");

        drive(32'h40, 1, 0, 32'h100, 1); tick();
        check(32'h40, "pre_async");
        drive(32'h44, 1, 0, 32'h700, 1);
        #2 nreset = 0;
        model_reset();
        check(32'h40, "async_reset");
        check(32'h44, "async_reset_upd");
        update_valid = 0;
        #20 nreset = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
